// File: rtl/multicycle_divider.sv
// ============================================================================
// Module   : multicycle_divider
// Purpose  : Iterative NxN integer divider for an RV32M execute stage.
//            Retires BITS_PER_CYCLE quotient bits per clock by restoring
//            division on operand magnitudes. Divide-by-zero and signed
//            overflow bypass the iteration, and sign correction is applied
//            in a dedicated FIXUP cycle. A flush aborts any operation.
// Ports    : CLK, nRST        clock, asynchronous active-low reset
//            start, flush     begin a new operation / abort (flush wins)
//            is_signed        1 = DIV/REM, 0 = DIVU/REMU
//            dividend/divisor operands, sampled only in the start cycle
//            busy, finished   operation in progress / result valid
//            quotient/remainder  RISC-V results
//            div_by_zero/overflow  special-case flags, valid with finished
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_divider #(
  parameter int N              = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         start,
  input  logic         flush,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         finished,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int ITERS = N / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);

  generate
    if (N < 4 || (N % 2) != 0 ||
        !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (N % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("multicycle_divider: illegal N / BITS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPECIAL = 3'd1,
    ITERATE = 3'd2,
    FIXUP   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, next_state;

  // quotient doubles as the dividend shift register during ITERATE: dividend
  // bits leave at the MSB while quotient bits enter at the LSB.
  logic [N-1:0]  quo_r;
  logic [N-1:0]  rem_r;
  logic [N-1:0]  divisor_mag;
  logic          neg_quo;
  logic          neg_rem;
  logic          is_dbz;
  logic          is_ovf;
  logic [CW-1:0] cnt;
  logic          dbz_out;
  logic          ovf_out;

  // ---------------- capture-time decode ----------------
  logic         a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;
  logic         cap_dbz, cap_ovf, cap_special;

  always_comb begin
    a_neg       = is_signed & dividend[N-1];
    b_neg       = is_signed & divisor[N-1];
    a_mag       = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag       = b_neg ? (~divisor + 1'b1) : divisor;
    cap_dbz     = (divisor == '0);
    cap_ovf     = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) &&
                  (divisor == '1);
    // Flags are mutually exclusive: divide-by-zero takes precedence.
    cap_ovf     = cap_ovf & ~cap_dbz;
    cap_special = cap_dbz | cap_ovf;
  end

  // ---------------- chained restoring steps ----------------
  logic [N-1:0] it_rem [0:BITS_PER_CYCLE];
  logic [N-1:0] it_quo [0:BITS_PER_CYCLE];
  logic [N:0]   shifted;
  logic [N:0]   trial;

  always_comb begin
    it_rem[0] = rem_r;
    it_quo[0] = quo_r;
    shifted   = '0;
    trial     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {it_rem[i], it_quo[i][N-1]};
      // N+1 bit subtract: bit N is the borrow, i.e. the trial went negative.
      trial   = shifted - {1'b0, divisor_mag};
      if (!trial[N]) begin
        it_rem[i+1] = trial[N-1:0];
        it_quo[i+1] = {it_quo[i][N-2:0], 1'b1};
      end else begin
        it_rem[i+1] = shifted[N-1:0];
        it_quo[i+1] = {it_quo[i][N-2:0], 1'b0};
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    finished   = 1'b0;
    case (state)
      SPECIAL: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      ITERATE: begin
        busy = 1'b1;
        if (cnt == CW'(1)) next_state = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE:    finished = 1'b1;
      default: next_state = state;
    endcase
    if (flush) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = cap_special ? SPECIAL : ITERATE;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      quo_r       <= '0;
      rem_r       <= '0;
      divisor_mag <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      is_dbz      <= 1'b0;
      is_ovf      <= 1'b0;
      cnt         <= CW'(ITERS);
      dbz_out     <= 1'b0;
      ovf_out     <= 1'b0;
    end else if (flush) begin
      // Results hold their last values; only the flags are withdrawn.
      dbz_out <= 1'b0;
      ovf_out <= 1'b0;
    end else if (start) begin
      // Special cases preload the raw dividend: it is already the remainder
      // for divide-by-zero and the quotient for overflow.
      quo_r       <= cap_special ? dividend : a_mag;
      rem_r       <= cap_special ? dividend : '0;
      divisor_mag <= b_mag;
      neg_quo     <= a_neg ^ b_neg;
      neg_rem     <= a_neg;
      is_dbz      <= cap_dbz;
      is_ovf      <= cap_ovf;
      cnt         <= CW'(ITERS);
      dbz_out     <= 1'b0;
      ovf_out     <= 1'b0;
    end else begin
      case (state)
        SPECIAL: begin
          if (is_dbz) begin
            quo_r   <= '1;
            dbz_out <= 1'b1;
          end else if (is_ovf) begin
            rem_r   <= '0;
            ovf_out <= 1'b1;
          end
        end
        ITERATE: begin
          quo_r <= it_quo[BITS_PER_CYCLE];
          rem_r <= it_rem[BITS_PER_CYCLE];
          cnt   <= cnt - CW'(1);
        end
        FIXUP: begin
          // Negating zero yields zero, so a zero quotient needs no guard.
          if (neg_quo) quo_r <= ~quo_r + 1'b1;
          if (neg_rem) rem_r <= ~rem_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_r;
  assign remainder   = rem_r;
  assign div_by_zero = dbz_out;
  assign overflow    = ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_divider.sv
// ============================================================================
// Module   : tb_multicycle_divider
// Purpose  : Self-checking bench for multicycle_divider. Two instances
//            (1 and 4 bits per cycle) share the same stimulus; results,
//            flags and latency are checked against constant vectors and a
//            plain-arithmetic RISC-V division model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_divider;

  localparam int N  = 32;
  localparam int L1 = 32;
  localparam int L4 = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;

  logic        busy1, fin1_s, dbz1, ovf1;
  logic [31:0] q1, r1;
  logic        busy4, fin4_s, dbz4, ovf4;
  logic [31:0] q4, r4;

  int compared   = 0;
  int mismatched = 0;

  multicycle_divider #(.N(N), .BITS_PER_CYCLE(1)) dut1 (
    .CLK(clk), .nRST(rst_n), .start(start), .flush(flush),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .busy(busy1), .finished(fin1_s), .quotient(q1), .remainder(r1),
    .div_by_zero(dbz1), .overflow(ovf1)
  );

  multicycle_divider #(.N(N), .BITS_PER_CYCLE(4)) dut4 (
    .CLK(clk), .nRST(rst_n), .start(start), .flush(flush),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .busy(busy4), .finished(fin4_s), .quotient(q4), .remainder(r4),
    .div_by_zero(dbz4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RISC-V division semantics with plain integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, output logic [31:0] q,
                                output logic [31:0] r, output logic dbz,
                                output logic ovf);
    int sa, sb;
    sa  = a;
    sb  = b;
    dbz = (b == 32'd0);
    ovf = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q   = a;
        r   = 32'd0;
        ovf = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; asserts start in the current cycle (cycle 0) and
  // returns at the negedge of the cycle in which the slower instance first
  // shows finished, so a following call starts back-to-back.
  task automatic run_op(input string name, input logic [31:0] a,
                        input logic [31:0] b, input logic sgn,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input logic eovf);
    int  cyc, f1, f4;
    bit  special;
    special   = edbz | eovf;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Operand changes after capture must be ignored.
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = $urandom_range(0, 1);
    cyc = 1;
    f1  = -1;
    f4  = -1;
    check({name, " busy1@1"}, busy1, 1);
    check({name, " busy4@1"}, busy4, 1);
    check({name, " fin1@1"}, fin1_s, 0);
    check({name, " fin4@1"}, fin4_s, 0);
    while (cyc < 60) begin
      if (f1 < 0 && fin1_s) begin
        f1 = cyc;
        check({name, " busy1@fin"}, busy1, 0);
      end
      if (f4 < 0 && fin4_s) begin
        f4 = cyc;
        check({name, " busy4@fin"}, busy4, 0);
      end
      if (!special && cyc == L4 + 1) check({name, " busy4@fixup"}, busy4, 1);
      if (f1 >= 0 && f4 >= 0) break;
      @(negedge clk);
      cyc++;
    end
    check({name, " lat1"}, f1, special ? 2 : L1 + 2);
    check({name, " lat4"}, f4, special ? 2 : L4 + 2);
    check({name, " q1"}, q1, eq);
    check({name, " r1"}, r1, er);
    check({name, " q4"}, q4, eq);
    check({name, " r4"}, r4, er);
    check({name, " dbz1"}, dbz1, edbz);
    check({name, " ovf1"}, ovf1, eovf);
    check({name, " dbz4"}, dbz4, edbz);
    check({name, " ovf4"}, ovf4, eovf);
  endtask

  task automatic run_model(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    logic        dz, ov;
    model(a, b, sgn, q, r, dz, ov);
    run_op(name, a, b, sgn, q, r, dz, ov);
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0, 1'b0};
    vecs[3]  = '{32'd5,         32'd0,         1'b1, 32'hFFFFFFFF,  32'd5,         1'b1, 1'b0};
    vecs[4]  = '{32'h80000000,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h80000000,  1'b1, 1'b0};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, 1'b1};
    vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0, 1'b0};
    vecs[7]  = '{32'd0,         32'hFFFFFFFB,  1'b1, 32'd0,         32'd0,         1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFEC,  32'hFFFFFFFD,  1'b1, 32'd6,         32'hFFFFFFFE,  1'b0, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0, 1'b0};
    vecs[10] = '{32'h80000000,  32'h80000000,  1'b1, 32'd1,         32'd0,         1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFF9,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst busy", busy1, 0);
    check("rst finished", fin1_s, 0);
    check("rst quotient", q1, 0);
    check("rst remainder", r1, 0);
    check("rst dbz", dbz1, 0);
    check("rst ovf", ovf1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
             vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
    end

    // Flush in cycle 10 of 100/7: no finished pulse afterwards.
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy1", busy1, 0);
    check("flush fin1", fin1_s, 0);
    check("flush busy4", busy4, 0);
    check("flush fin4", fin4_s, 0);
    check("flush dbz1", dbz1, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (fin1_s || fin4_s || busy1 || busy4) seen = 1'b1;
    end
    check("flush no activity", seen, 0);
    run_op("after flush", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0);

    // start and flush together: flush wins, nothing captured.
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", busy1, 0);
    check("start+flush fin", fin1_s, 0);
    repeat (3) @(negedge clk);
    check("start+flush idle", busy1 | busy4 | fin1_s | fin4_s, 0);

    // Restart mid-operation at cycle 5; latency counts from the new start.
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    run_model("restart", 32'hFFFF1234, 32'd77, 1'b1);

    // Asynchronous reset mid-operation.
    dividend = 32'h12345678; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", busy1, 0);
    check("async rst quotient", q1, 0);
    check("async rst remainder", r1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = $urandom_range(0, 15);
        1: b = 32'd0;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = b >> $urandom_range(1, 31);
        4: a = a >> $urandom_range(1, 31);
        default: ;
      endcase
      run_model($sformatf("rand%0d", i), a, b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
